// File: rtl/gayle_xfer_ctrl_if.sv
// Handshake and FIFO-control bundle of the Gayle IDE data-phase controller.
// The controller uses the slave view; the environment (CPU/host/FIFO side) uses master.
interface gayle_xfer_ctrl_if;
    logic       cmd_start;
    logic       cmd_dir;
    logic [7:0] cmd_count;
    logic       cmd_abort;
    logic       cpu_data_rd;
    logic       cpu_data_wr;
    logic       hst_wr;
    logic       hst_rd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_last;
    logic       fifo_rd;
    logic       fifo_wr;
    logic       fifo_reset;
    logic       bsy;
    logic       drq;
    logic       irq;
    logic       hst_req;
    logic       done;
    logic       err;
    logic [8:0] sectors_left;

    modport slave (
        input  cmd_start, cmd_dir, cmd_count, cmd_abort,
        input  cpu_data_rd, cpu_data_wr, hst_wr, hst_rd,
        input  fifo_full, fifo_empty, fifo_last,
        output fifo_rd, fifo_wr, fifo_reset,
        output bsy, drq, irq, hst_req, done, err, sectors_left
    );

    modport master (
        output cmd_start, cmd_dir, cmd_count, cmd_abort,
        output cpu_data_rd, cpu_data_wr, hst_wr, hst_rd,
        output fifo_full, fifo_empty, fifo_last,
        input  fifo_rd, fifo_wr, fifo_reset,
        input  bsy, drq, irq, hst_req, done, err, sectors_left
    );
endinterface

// File: rtl/gayle_xfer_ctrl.sv
// ATA PIO data-phase sequencer: moves multi-sector READ/WRITE data through the
// sector FIFO between host and CPU, and drives BSY/DRQ/IRQ and the FIFO strobes.
module gayle_xfer_ctrl (
    input  logic              clk,
    input  logic              clk7_en,
    input  logic              reset,
    gayle_xfer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOST  = 2'd2,
        ST_CPU   = 2'd3
    } state_t;

    // A sector count of zero encodes the full 256-sector transfer.
    function automatic logic [8:0] count_to_sectors(input logic [7:0] cnt);
        count_to_sectors = (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
    endfunction

    state_t     state_r;
    logic       dir_r;
    logic [7:0] wcnt_r;
    logic [8:0] sectors_left_r;
    logic       bsy_r;
    logic       drq_r;
    logic       irq_r;
    logic       hst_req_r;
    logic       done_r;
    logic       err_r;
    logic       fifo_reset_r;

    logic       active_s;
    logic       fifo_rd_s;
    logic       fifo_wr_s;
    logic       last_rd_s;
    logic       proto_err_s;

    // Strobe qualification and protocol-error detection for the current cycle.
    always_comb begin
        active_s    = (state_r != ST_IDLE);
        fifo_rd_s   = ((state_r == ST_CPU) && !dir_r && drq_r &&
                       bus.cpu_data_rd && !bus.fifo_empty) ||
                      ((state_r == ST_HOST) && dir_r &&
                       bus.hst_rd && !bus.fifo_empty);
        // Host writes stay accepted in CPU phase so later sectors can prefetch.
        fifo_wr_s   = (!dir_r && ((state_r == ST_HOST) || (state_r == ST_CPU)) &&
                       bus.hst_wr) ||
                      (dir_r && (state_r == ST_CPU) && drq_r && bus.cpu_data_wr);
        last_rd_s   = fifo_rd_s && bus.fifo_last;
        proto_err_s = ((bus.cpu_data_rd || bus.cpu_data_wr) && !drq_r) ||
                      (bus.cpu_data_rd && bus.fifo_empty) ||
                      (bus.hst_wr && active_s && dir_r) ||
                      (bus.hst_rd && active_s && !dir_r) ||
                      (bus.cmd_start && active_s);
    end

    assign bus.fifo_rd      = clk7_en & fifo_rd_s;
    assign bus.fifo_wr      = clk7_en & fifo_wr_s;
    assign bus.fifo_reset   = fifo_reset_r;
    assign bus.bsy          = bsy_r;
    assign bus.drq          = drq_r;
    assign bus.irq          = irq_r;
    assign bus.hst_req      = hst_req_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.sectors_left = sectors_left_r;

    // Transfer state machine with all status outputs registered.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state_r        <= ST_IDLE;
                dir_r          <= 1'b0;
                wcnt_r         <= 8'd0;
                sectors_left_r <= 9'd0;
                bsy_r          <= 1'b0;
                drq_r          <= 1'b0;
                irq_r          <= 1'b0;
                hst_req_r      <= 1'b0;
                done_r         <= 1'b0;
                err_r          <= 1'b0;
                fifo_reset_r   <= 1'b0;
            end else begin
                irq_r        <= 1'b0;
                done_r       <= 1'b0;
                fifo_reset_r <= 1'b0;
                if (proto_err_s) begin
                    err_r <= 1'b1;
                end
                // Abort outranks a simultaneous start and any sector completion.
                if (bus.cmd_abort) begin
                    state_r        <= ST_IDLE;
                    fifo_reset_r   <= 1'b1;
                    sectors_left_r <= 9'd0;
                    bsy_r          <= 1'b0;
                    drq_r          <= 1'b0;
                    hst_req_r      <= 1'b0;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            if (bus.cmd_start) begin
                                sectors_left_r <= count_to_sectors(bus.cmd_count);
                                dir_r          <= bus.cmd_dir;
                                wcnt_r         <= 8'd0;
                                err_r          <= proto_err_s;
                                state_r        <= ST_FLUSH;
                                fifo_reset_r   <= 1'b1;
                                bsy_r          <= 1'b1;
                            end
                        end
                        ST_FLUSH: begin
                            if (dir_r) begin
                                state_r   <= ST_CPU;
                                bsy_r     <= 1'b0;
                                drq_r     <= 1'b1;
                                hst_req_r <= 1'b0;
                            end else begin
                                state_r   <= ST_HOST;
                                bsy_r     <= 1'b1;
                                drq_r     <= 1'b0;
                                hst_req_r <= 1'b1;
                            end
                        end
                        ST_HOST: begin
                            if (!dir_r) begin
                                if (bus.fifo_full) begin
                                    state_r   <= ST_CPU;
                                    irq_r     <= 1'b1;
                                    bsy_r     <= 1'b0;
                                    drq_r     <= 1'b1;
                                    hst_req_r <= (sectors_left_r > 9'd1);
                                end
                            end else if (last_rd_s) begin
                                irq_r <= 1'b1;
                                bsy_r <= 1'b0;
                                if (sectors_left_r <= 9'd1) begin
                                    state_r        <= ST_IDLE;
                                    done_r         <= 1'b1;
                                    sectors_left_r <= 9'd0;
                                    drq_r          <= 1'b0;
                                    hst_req_r      <= 1'b0;
                                end else begin
                                    state_r        <= ST_CPU;
                                    sectors_left_r <= sectors_left_r - 9'd1;
                                    drq_r          <= 1'b1;
                                    hst_req_r      <= 1'b0;
                                end
                            end
                        end
                        ST_CPU: begin
                            if (!dir_r) begin
                                if (last_rd_s) begin
                                    drq_r <= 1'b0;
                                    if (sectors_left_r <= 9'd1) begin
                                        state_r        <= ST_IDLE;
                                        done_r         <= 1'b1;
                                        sectors_left_r <= 9'd0;
                                        hst_req_r      <= 1'b0;
                                    end else begin
                                        state_r        <= ST_HOST;
                                        sectors_left_r <= sectors_left_r - 9'd1;
                                        bsy_r          <= 1'b1;
                                        hst_req_r      <= 1'b1;
                                    end
                                end
                            end else if (fifo_wr_s) begin
                                wcnt_r <= wcnt_r + 8'd1;
                                // The 256th word of a sector hands it to the host.
                                if (wcnt_r == 8'd255) begin
                                    state_r   <= ST_HOST;
                                    bsy_r     <= 1'b1;
                                    drq_r     <= 1'b0;
                                    hst_req_r <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_r   <= ST_IDLE;
                            bsy_r     <= 1'b0;
                            drq_r     <= 1'b0;
                            hst_req_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// Directed bench for gayle_xfer_ctrl with a behavioural sector-FIFO occupancy model.
module tb_gayle_xfer_ctrl;

    logic clk = 1'b0;
    logic clk7_en;
    logic reset;

    gayle_xfer_ctrl_if bus ();

    gayle_xfer_ctrl dut (
        .clk     (clk),
        .clk7_en (clk7_en),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned f_cnt      = 0;
    int unsigned f_rdidx    = 0;
    int unsigned wr_total   = 0;
    int unsigned rd_total   = 0;
    int unsigned irq_total  = 0;
    int unsigned done_total = 0;

    // FIFO occupancy and read-position model driven by the DUT strobes.
    always @(posedge clk) begin
        if (clk7_en === 1'b1) begin
            if (bus.fifo_reset) begin
                f_cnt   <= 0;
                f_rdidx <= 0;
            end else begin
                f_cnt   <= f_cnt + {31'd0, bus.fifo_wr} - {31'd0, bus.fifo_rd};
                f_rdidx <= f_rdidx + {31'd0, bus.fifo_rd};
            end
            wr_total <= wr_total + {31'd0, bus.fifo_wr};
            rd_total <= rd_total + {31'd0, bus.fifo_rd};
        end
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        irq_total  <= irq_total + {31'd0, bus.irq};
        done_total <= done_total + {31'd0, bus.done};
    end

    assign bus.fifo_full  = (f_cnt >= 256);
    assign bus.fifo_empty = (f_cnt == 0);
    assign bus.fifo_last  = (f_cnt != 0) && ((f_rdidx % 256) == 255);

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic dir, input logic [7:0] cnt);
        bus.cmd_start = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_count = cnt;
        step();
        bus.cmd_start = 1'b0;
    endtask

    task automatic abort_cmd();
        bus.cmd_abort = 1'b1;
        step();
        bus.cmd_abort = 1'b0;
    endtask

    int unsigned irq0, done0, wr0, rd0;
    int          reads, writes, drains, lows, seen;
    int          low_sl[$];

    initial begin
        clk7_en         = 1'b1;
        reset           = 1'b1;
        bus.cmd_start   = 1'b0;
        bus.cmd_dir     = 1'b0;
        bus.cmd_count   = 8'd0;
        bus.cmd_abort   = 1'b0;
        bus.cpu_data_rd = 1'b0;
        bus.cpu_data_wr = 1'b0;
        bus.hst_wr      = 1'b0;
        bus.hst_rd      = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_eq("rst_bsy", bus.bsy, 1'b0);
        chk_eq("rst_drq", bus.drq, 1'b0);
        chk_eq("rst_irq", bus.irq, 1'b0);
        chk_eq("rst_hst_req", bus.hst_req, 1'b0);
        chk_eq("rst_done", bus.done, 1'b0);
        chk_eq("rst_err", bus.err, 1'b0);
        chk_eq("rst_fifo_reset", bus.fifo_reset, 1'b0);
        chk_eq("rst_sl", bus.sectors_left, 9'd0);

        // READ, one sector
        irq0 = irq_total; done0 = done_total; wr0 = wr_total; rd0 = rd_total;
        start_cmd(1'b0, 8'd1);
        chk_eq("r1_flush_fr", bus.fifo_reset, 1'b1);
        chk_eq("r1_flush_bsy", bus.bsy, 1'b1);
        chk_eq("r1_sl", bus.sectors_left, 9'd1);
        step();
        chk_eq("r1_host_req", bus.hst_req, 1'b1);
        chk_eq("r1_host_bsy", bus.bsy, 1'b1);
        chk_eq("r1_host_drq", bus.drq, 1'b0);
        bus.hst_wr = 1'b1;
        for (int i = 0; i < 256; i++) step();
        bus.hst_wr = 1'b0;
        step();
        chk_eq("r1_irq", bus.irq, 1'b1);
        chk_eq("r1_drq", bus.drq, 1'b1);
        chk_eq("r1_bsy", bus.bsy, 1'b0);
        chk_eq("r1_wr_count", wr_total - wr0, 256);
        bus.cpu_data_rd = 1'b1;
        #1;
        chk_eq("r1_fifo_rd_comb", bus.fifo_rd, 1'b1);
        for (int i = 0; i < 256; i++) step();
        bus.cpu_data_rd = 1'b0;
        chk_eq("r1_done", bus.done, 1'b1);
        chk_eq("r1_sl_end", bus.sectors_left, 9'd0);
        chk_eq("r1_drq_end", bus.drq, 1'b0);
        chk_eq("r1_err", bus.err, 1'b0);
        chk_eq("r1_rd_count", rd_total - rd0, 256);
        chk_eq("r1_irq_count", irq_total - irq0, 1);
        step();
        chk_eq("r1_done_width", bus.done, 1'b0);

        // READ, three sectors fully prefetched by the host
        irq0 = irq_total; done0 = done_total;
        start_cmd(1'b0, 8'd3);
        step();
        bus.hst_wr = 1'b1;
        for (int i = 0; i < 768; i++) step();
        bus.hst_wr = 1'b0;
        chk_eq("r3_hst_req_cpu", bus.hst_req, 1'b1);
        reads = 0;
        lows  = 0;
        for (int c = 0; c < 1000 && reads < 768; c++) begin
            if (bus.drq) begin
                bus.cpu_data_rd = 1'b1;
                reads++;
            end else begin
                bus.cpu_data_rd = 1'b0;
                if (reads > 0) begin
                    lows++;
                    low_sl.push_back(int'(bus.sectors_left));
                end
            end
            step();
        end
        bus.cpu_data_rd = 1'b0;
        chk_eq("r3_reads", reads, 768);
        chk_eq("r3_drq_low_cycles", lows, 2);
        chk_eq("r3_sl_first", (low_sl.size() > 0) ? low_sl[0] : -1, 2);
        chk_eq("r3_sl_second", (low_sl.size() > 1) ? low_sl[1] : -1, 1);
        chk_eq("r3_done", bus.done, 1'b1);
        chk_eq("r3_sl_end", bus.sectors_left, 9'd0);
        step();
        chk_eq("r3_irq_count", irq_total - irq0, 3);
        chk_eq("r3_done_count", done_total - done0, 1);

        // WRITE, 256 sectors: first two sector handoffs, then abort
        irq0 = irq_total; done0 = done_total;
        start_cmd(1'b1, 8'd0);
        chk_eq("w256_sl", bus.sectors_left, 9'd256);
        chk_eq("w256_flush_bsy", bus.bsy, 1'b1);
        step();
        chk_eq("w256_drq", bus.drq, 1'b1);
        chk_eq("w256_bsy", bus.bsy, 1'b0);
        chk_eq("w256_irq", bus.irq, 1'b0);
        bus.cpu_data_wr = 1'b1;
        for (int i = 0; i < 255; i++) step();
        chk_eq("w256_drq_255", bus.drq, 1'b1);
        step();
        bus.cpu_data_wr = 1'b0;
        chk_eq("w256_host_bsy", bus.bsy, 1'b1);
        chk_eq("w256_host_req", bus.hst_req, 1'b1);
        chk_eq("w256_host_drq", bus.drq, 1'b0);
        chk_eq("w256_no_irq", irq_total - irq0, 0);
        bus.hst_rd = 1'b1;
        for (int i = 0; i < 256; i++) step();
        bus.hst_rd = 1'b0;
        chk_eq("w256_drain_irq", bus.irq, 1'b1);
        chk_eq("w256_drain_drq", bus.drq, 1'b1);
        chk_eq("w256_drain_sl", bus.sectors_left, 9'd255);
        chk_eq("w256_drain_done", bus.done, 1'b0);
        abort_cmd();
        chk_eq("w256_abort_sl", bus.sectors_left, 9'd0);
        chk_eq("w256_abort_fr", bus.fifo_reset, 1'b1);

        // WRITE, two sectors to completion
        irq0 = irq_total; done0 = done_total; wr0 = wr_total; rd0 = rd_total;
        step();
        start_cmd(1'b1, 8'd2);
        step();
        writes = 0;
        drains = 0;
        seen   = 0;
        for (int c = 0; c < 1400 && seen == 0; c++) begin
            if (bus.done) begin
                seen = 1;
                chk_eq("w2_done_with_irq", bus.irq, 1'b1);
            end else begin
                bus.cpu_data_wr = bus.drq && (writes < 512);
                if (bus.cpu_data_wr) writes++;
                bus.hst_rd = bus.hst_req && (drains < 512);
                if (bus.hst_rd) drains++;
                step();
            end
        end
        bus.cpu_data_wr = 1'b0;
        bus.hst_rd      = 1'b0;
        chk_eq("w2_done_seen", seen, 1);
        step();
        chk_eq("w2_irq_count", irq_total - irq0, 2);
        chk_eq("w2_done_count", done_total - done0, 1);
        chk_eq("w2_fifo_wr", wr_total - wr0, 512);
        chk_eq("w2_fifo_rd", rd_total - rd0, 512);
        chk_eq("w2_sl", bus.sectors_left, 9'd0);
        chk_eq("w2_err", bus.err, 1'b0);

        // Abort during READ CPU phase after 100 words
        done0 = done_total;
        start_cmd(1'b0, 8'd2);
        step();
        bus.hst_wr = 1'b1;
        for (int i = 0; i < 256; i++) step();
        bus.hst_wr = 1'b0;
        step();
        bus.cpu_data_rd = 1'b1;
        for (int i = 0; i < 100; i++) step();
        bus.cpu_data_rd = 1'b0;
        abort_cmd();
        chk_eq("ab_drq", bus.drq, 1'b0);
        chk_eq("ab_fifo_reset", bus.fifo_reset, 1'b1);
        chk_eq("ab_sl", bus.sectors_left, 9'd0);
        chk_eq("ab_bsy", bus.bsy, 1'b0);
        chk_eq("ab_hst_req", bus.hst_req, 1'b0);
        step();
        chk_eq("ab_fifo_reset_width", bus.fifo_reset, 1'b0);
        chk_eq("ab_no_done", done_total - done0, 0);

        // Protocol errors
        bus.cpu_data_rd = 1'b1;
        #1;
        chk_eq("pe_no_fifo_rd", bus.fifo_rd, 1'b0);
        step();
        bus.cpu_data_rd = 1'b0;
        chk_eq("pe_cpu_rd_err", bus.err, 1'b1);
        start_cmd(1'b0, 8'd1);
        chk_eq("pe_start_clears", bus.err, 1'b0);
        step();
        bus.hst_rd = 1'b1;
        step();
        bus.hst_rd = 1'b0;
        chk_eq("pe_hst_rd_err", bus.err, 1'b1);
        abort_cmd();
        step();
        start_cmd(1'b0, 8'd1);
        chk_eq("pe_err_clear2", bus.err, 1'b0);
        step();
        start_cmd(1'b0, 8'd1);
        chk_eq("pe_start_busy_err", bus.err, 1'b1);
        chk_eq("pe_start_busy_host", bus.hst_req, 1'b1);
        abort_cmd();

        // Simultaneous start and abort while idle
        step();
        bus.cmd_abort = 1'b1;
        start_cmd(1'b0, 8'd5);
        bus.cmd_abort = 1'b0;
        chk_eq("sa_fifo_reset", bus.fifo_reset, 1'b1);
        chk_eq("sa_bsy", bus.bsy, 1'b0);
        chk_eq("sa_sl", bus.sectors_left, 9'd0);
        step();
        chk_eq("sa_fr_width", bus.fifo_reset, 1'b0);
        chk_eq("sa_idle_bsy", bus.bsy, 1'b0);

        // Clock enable gating and mid-transfer reset
        clk7_en = 1'b0;
        start_cmd(1'b0, 8'd4);
        chk_eq("ce_start_ignored", bus.bsy, 1'b0);
        clk7_en = 1'b1;
        bus.cmd_start = 1'b1;
        step();
        bus.cmd_start = 1'b0;
        clk7_en = 1'b0;
        step();
        step();
        chk_eq("ce_hold_fr", bus.fifo_reset, 1'b1);
        chk_eq("ce_hold_req", bus.hst_req, 1'b0);
        clk7_en = 1'b1;
        step();
        chk_eq("ce_host_req", bus.hst_req, 1'b1);
        chk_eq("ce_host_sl", bus.sectors_left, 9'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_eq("mr_hst_req", bus.hst_req, 1'b0);
        chk_eq("mr_bsy", bus.bsy, 1'b0);
        chk_eq("mr_sl", bus.sectors_left, 9'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
